// File: rtl/gpmc_wb_arbiter.sv
`default_nettype none
// gpmc_wb_arbiter: two-master round-robin Wishbone arbiter with a slave-hang watchdog.
// Rev 1.0 - initial release.
module gpmc_wb_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  input  logic                  m0_cycle,
  input  logic                  m0_strobe,
  input  logic                  m0_write,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  input  logic                  m1_cycle,
  input  logic                  m1_strobe,
  input  logic                  m1_write,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  output logic                  s_cycle,
  output logic                  s_strobe,
  output logic                  s_write,
  input  logic                  s_ack,
  output logic [1:0]            grant,
  output logic                  timeout_seen
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_seen_q, timeout_seen_d;

  logic own_cycle;
  logic own_strobe;
  logic tmo_fire;

  assign own_cycle  = ((state_q == ST_OWN0) && m0_cycle)  || ((state_q == ST_OWN1) && m1_cycle);
  assign own_strobe = ((state_q == ST_OWN0) && m0_strobe) || ((state_q == ST_OWN1) && m1_strobe);
  // A same-cycle ack always beats the watchdog.
  assign tmo_fire   = own_strobe && !s_ack && (cnt_q == TMO_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      last_owner_q   <= 1'b1;
      cnt_q          <= 8'd0;
      timeout_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      cnt_q          <= cnt_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    cnt_d          = 8'd0;
    timeout_seen_d = timeout_seen_q | tmo_fire;
    if (own_cycle && own_strobe && !s_ack && !tmo_fire) cnt_d = cnt_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (m0_cycle && m1_cycle) state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        else if (m0_cycle)        state_d = ST_OWN0;
        else if (m1_cycle)        state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_cycle) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!m1_cycle) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_address   = '0;
    s_writedata = '0;
    s_cycle     = 1'b0;
    s_strobe    = 1'b0;
    s_write     = 1'b0;
    m0_readdata = '0;
    m0_ack      = 1'b0;
    m0_err      = 1'b0;
    m1_readdata = '0;
    m1_ack      = 1'b0;
    m1_err      = 1'b0;
    grant       = 2'b00;
    case (state_q)
      ST_OWN0: begin
        grant       = 2'b01;
        s_address   = m0_address;
        s_writedata = m0_writedata;
        s_cycle     = m0_cycle;
        s_strobe    = m0_strobe & ~tmo_fire;
        s_write     = m0_write;
        m0_readdata = s_readdata;
        m0_ack      = s_ack & m0_strobe;
        m0_err      = tmo_fire;
      end
      ST_OWN1: begin
        grant       = 2'b10;
        s_address   = m1_address;
        s_writedata = m1_writedata;
        s_cycle     = m1_cycle;
        s_strobe    = m1_strobe & ~tmo_fire;
        s_write     = m1_write;
        m1_readdata = s_readdata;
        m1_ack      = s_ack & m1_strobe;
        m1_err      = tmo_fire;
      end
      default: ;
    endcase
  end

  assign timeout_seen = timeout_seen_q;

endmodule
`default_nettype wire

// File: doc/gpmc_wb_arbiter.md
Name: gpmc_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter with bus-timeout watchdog.
- Master 0 is the GPMC-to-Wishbone bridge output.
- Master 1 is an internal FPGA master (DMA/self-test engine).
- The shared slave port drives the peripheral address space. The block sequences ownership with round-robin fairness and terminates hung slave transfers so the GPMC host never stalls indefinitely.

Parameters:
- ADDR_WIDTH, 16, width of the Wishbone address on all ports.
- DATA_WIDTH, 16, width of the Wishbone data on all ports.
- TIMEOUT, 255, slave wait cycles without ack before the transfer is aborted; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- m0_address  input  ADDR_WIDTH  master 0 address
- m0_writedata  input  DATA_WIDTH  master 0 write data
- m0_readdata  output  DATA_WIDTH  master 0 read data
- m0_cycle  input  1  master 0 bus cycle request/hold
- m0_strobe  input  1  master 0 data strobe
- m0_write  input  1  master 0 write enable
- m0_ack  output  1  master 0 acknowledge
- m0_err  output  1  master 0 timeout error termination
- m1_address, m1_writedata, m1_readdata, m1_cycle, m1_strobe, m1_write, m1_ack, m1_err: same as m0_*, for master 1
- s_address  output  ADDR_WIDTH  slave address
- s_writedata  output  DATA_WIDTH  slave write data
- s_readdata  input  DATA_WIDTH  slave read data
- s_cycle  output  1  slave cycle
- s_strobe  output  1  slave strobe
- s_write  output  1  slave write enable
- s_ack  input  1  slave acknowledge
- grant  output  2  one-hot owner: bit0 = m0, bit1 = m1; 00 = idle
- timeout_seen  output  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (async, reset = 0):
  - state IDLE, grant = 00, last_owner = 1 (so m0 wins the first tie).
  - Timeout counter = 0, timeout_seen = 0.
  - All s_* outputs 0; all m*_ack, m*_err, m*_readdata = 0.
  - Reset mid-transfer aborts immediately; no ack or err is issued.
- State machine: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_cycle high -> OWN0. Only m1_cycle high -> OWN1.
  - Both high -> the master that is not last_owner.
  - Neither high -> stay in IDLE.
  - Grant is registered: the first slave-visible cycle is the clock after the request is sampled.
- OWNx:
  - s_address, s_writedata and s_write are combinationally muxed from master x.
  - s_cycle = mx_cycle; s_strobe = mx_strobe, except forced to 0 in the timeout cycle.
- Release:
  - Owner drops mx_cycle -> back to IDLE, and last_owner = x.
  - One mandatory IDLE cycle always separates grants (s_cycle low for ≥1 clk).
  - Grant is never preempted while the owner holds cycle; multi-beat cycles stay with the owner.
- Ack routing:
  - mx_ack = s_ack & grant[x] & mx_strobe, combinational (zero added latency).
  - Non-owner ack/err are always 0.
- Read data: mx_readdata = s_readdata when grant[x], else 0.
- Watchdog:
  - Counter increments each clk while in OWNx with mx_strobe = 1 and s_ack = 0.
  - Clears on s_ack, on strobe low, or on leaving OWNx.
  - When the counter equals TIMEOUT:
    - mx_err = 1 for exactly one cycle, s_strobe forced to 0 that cycle.
    - Counter clears and timeout_seen is set.
    - The owner keeps the grant until it drops cycle.
- Simultaneous s_ack and timeout compare in the same cycle: ack wins, no err, counter clears.
- s_ack while in IDLE, or while the owner strobe is low: ignored and not routed.
- Width rules: the counter is 8 bits; TIMEOUT > 255 is not supported.

Test Plan:
- Single master:
  - m0 write, address 0x0010, data 0xDEAD; slave acks 2 cycles after strobe.
  - Expect grant = 01 one clk after the cycle request, s_address = 0x0010, s_writedata = 0xDEAD, and m0_ack in the same clk as s_ack.
  - Expect grant = 00 the clk after m0_cycle falls.
- Tie and round-robin:
  - m0 and m1 assert cycle in the same clk after reset -> m0 served first (grant = 01).
  - Then one IDLE cycle, then grant = 10.
  - A second simultaneous request -> m0 again (alternation holds).
- Read isolation:
  - m1 owns and reads address 0xAAAA; slave returns 0xF0F0 -> m1_readdata = 0xF0F0.
  - m0_readdata = 0 and m0_ack = 0 throughout.
- Timeout:
  - TIMEOUT = 8; m0 strobes and the slave never acks.
  - Expect m0_err high for exactly 1 clk, 8 clks after the first strobe cycle, s_strobe low that clk, and timeout_seen = 1.
  - m1 stays blocked until m0 drops cycle.
- Ack/timeout collision: s_ack asserted exactly on the 8th wait cycle -> m0_ack = 1, m0_err = 0, timeout_seen remains 0.
- Async reset mid-transfer:
  - Drive reset low during OWN1 with strobe high, between clock edges.
  - Expect s_cycle, s_strobe, grant and m1_ack at 0 immediately.
  - After release, a simultaneous request grants m0 first.
